// File: rtl/floppy_drive_sequencer.sv
// floppy_drive_sequencer: owns the head position (track/side) fed to the track encoder,
// models motor spin-up and step settle time, holds the encoder in reset across head
// changes, and generates the byte-rate strobe.
// Optional feature macro: FLOPPY_SEQ_INDEX_EN builds the revolution position counter
// and the index pulse; without it o_index is tied low.
module floppy_drive_sequencer #(
  parameter int unsigned BYTE_DIV     = 128,
  parameter int unsigned SECTOR_BYTES = 782,
  parameter int unsigned SPINUP_BYTES = 4096,
  parameter int unsigned SETTLE_BYTES = 768,
  parameter int unsigned MAX_TRACK    = 79,
  parameter int unsigned INDEX_BYTES  = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_motor_on,
  input  logic       i_disk_in,
  input  logic       i_step_req,
  input  logic       i_step_dir,
  input  logic       i_side_sel,
  input  logic       i_sides,
  output logic [6:0] o_track,
  output logic       o_side,
  output logic       o_enc_rst,
  output logic       o_byte_stb,
  output logic       o_index,
  output logic       o_tk0,
  output logic       o_ready,
  output logic       o_busy
);

  localparam int unsigned DIV_W   = (BYTE_DIV > 2) ? $clog2(BYTE_DIV) : 1;
  localparam int unsigned CNT_MAX = (SPINUP_BYTES > SETTLE_BYTES) ? SPINUP_BYTES : SETTLE_BYTES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(BYTE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE     = DIV_W'(BYTE_DIV - 2);
  localparam logic [CNT_W-1:0] SPIN_LAST   = CNT_W'(SPINUP_BYTES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_BYTES - 1);
  localparam logic [6:0]       TRACK_MAX   = 7'(MAX_TRACK);

  // Reject geometry that the counters cannot represent.
  if (BYTE_DIV < 2 || SECTOR_BYTES == 0 || INDEX_BYTES == 0 || MAX_TRACK > 127 ||
      SPINUP_BYTES == 0 || SETTLE_BYTES == 0) begin : g_param_check
    $error("floppy_drive_sequencer: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SPIN   = 2'd1,
    S_RUN    = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [DIV_W-1:0] r_div;
  logic             r_byte_stb;
  logic [6:0]       r_track;
  logic [6:0]       w_track_next;
  logic [6:0]       w_track_step;
  logic             r_side;
  logic             w_side_next;
  logic             w_eff_side;
  logic             w_step_ok;
  logic             w_drive_on;
  logic             r_enc_rst;
  logic             r_ready;
  logic             r_busy;

  assign w_eff_side = i_side_sel & i_sides;
  assign w_drive_on = i_motor_on & i_disk_in;
  assign w_step_ok  = i_step_req && (r_state != S_SETTLE);

  // Byte-rate divider; the strobe is registered one count early so it is high at div == BYTE_DIV-1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div      <= '0;
      r_byte_stb <= 1'b0;
    end else begin
      r_div      <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      r_byte_stb <= (r_div == DIV_PRE);
    end
  end

  // Saturating single-track step target.
  always_comb begin
    w_track_step = r_track;
    if (i_step_dir) begin
      if (r_track != TRACK_MAX) w_track_step = r_track + 7'd1;
    end else begin
      if (r_track != 7'd0) w_track_step = r_track - 7'd1;
    end
  end

  // Next state and byte-tick counter; head changes never land in the clk RUN begins.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_drive_on) begin
          w_state_next = S_SPIN;
          w_cnt_next   = '0;
        end
      end
      S_SPIN: begin
        if (r_byte_stb) begin
          if (r_cnt == SPIN_LAST) begin
            // A step arriving on the last spin-up byte needs its own settle.
            w_state_next = i_step_req ? S_SETTLE : S_RUN;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      S_RUN: begin
        if (i_step_req || (w_eff_side != r_side)) begin
          w_state_next = S_SETTLE;
          w_cnt_next   = '0;
        end
      end
      S_SETTLE: begin
        if (r_byte_stb) begin
          if (r_cnt == SETTLE_LAST) begin
            w_state_next = S_RUN;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
    if (!w_drive_on) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end
    w_track_next = w_step_ok ? w_track_step : r_track;
    // Side follows the request except on the clk streaming starts; RUN then sees any difference.
    w_side_next  = (w_state_next == S_RUN) ? r_side : w_eff_side;
  end

  // State register with status outputs registered from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_track   <= 7'd0;
      r_side    <= 1'b0;
      r_enc_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_track   <= w_track_next;
      r_side    <= w_side_next;
      r_enc_rst <= (w_state_next != S_RUN);
      r_ready   <= (w_state_next == S_RUN);
      r_busy    <= (w_state_next == S_SPIN) || (w_state_next == S_SETTLE);
    end
  end

`ifdef FLOPPY_SEQ_INDEX_EN
  localparam int unsigned POS_W = $clog2(12 * SECTOR_BYTES);

  logic [3:0]       w_spt;
  logic [POS_W-1:0] w_pos_last;
  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] w_pos_next;
  logic             r_index;

  // Sectors per track by speed zone, and the revolution position while streaming.
  always_comb begin
    case (r_track[6:4])
      3'd0:    w_spt = 4'd12;
      3'd1:    w_spt = 4'd11;
      3'd2:    w_spt = 4'd10;
      3'd3:    w_spt = 4'd9;
      default: w_spt = 4'd8;
    endcase
    w_pos_last = POS_W'(32'(w_spt) * SECTOR_BYTES - 32'd1);
    w_pos_next = '0;
    if ((r_state == S_RUN) && (w_state_next == S_RUN)) begin
      w_pos_next = r_pos;
      if (r_byte_stb) w_pos_next = (r_pos == w_pos_last) ? '0 : r_pos + POS_W'(1);
    end
  end

  // Position register and index pulse over the first bytes of each revolution.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pos   <= '0;
      r_index <= 1'b0;
    end else begin
      r_pos   <= w_pos_next;
      r_index <= (w_state_next == S_RUN) && (32'(w_pos_next) < INDEX_BYTES);
    end
  end

  assign o_index = r_index;
`else
  assign o_index = 1'b0;
`endif

  assign o_track    = r_track;
  assign o_side     = r_side;
  assign o_enc_rst  = r_enc_rst;
  assign o_byte_stb = r_byte_stb;
  assign o_ready    = r_ready;
  assign o_busy     = r_busy;
  assign o_tk0      = (r_track == 7'd0);

endmodule
